// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam int unsigned REG_W           = 5;
    localparam logic [REG_W-1:0] REG_ZERO   = 5'd0;
    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned MEM_TIMEOUT_DEF = 64;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, MEM-stage branch flushes,
// multi-cycle memory freezes with timeout, plus stall/flush perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned TO_W        = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);

    state_t          r_state;
    state_t          w_next;
    logic [TO_W-1:0] r_wait;
    logic [TO_W-1:0] w_wait_nxt;
    logic            r_mem_timeout;
    logic            w_timeout_set;
    logic            w_stall_inc;
    logic            w_flush_inc;
    logic            w_wait_cond;
    logic            w_hazard;

    assign w_wait_cond = mem_req & ~mem_ready;
    assign w_hazard    = ex_mem_read & (ex_rd != REG_ZERO) &
                         ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= RUN;
            r_wait        <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = RUN;
        w_wait_nxt    = '0;
        w_timeout_set = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        freeze        = 1'b0;

        case (r_state)
            MEM_WAIT: begin
                if (w_wait_cond) begin
                    if (r_wait == TO_W'(MEM_TIMEOUT)) begin
                        // Give up on the access: drop it and let the pipe move.
                        w_timeout_set = 1'b1;
                        ex_mem_flush  = 1'b1;
                    end else begin
                        freeze      = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        w_stall_inc = 1'b1;
                        w_wait_nxt  = r_wait + TO_W'(1);
                        w_next      = MEM_WAIT;
                    end
                end
            end
            default: begin
                // RUN, LOAD_STALL and FLUSH share priorities; only RUN checks
                // load-use, and FLUSH ignores branches since MEM holds a bubble.
                if (w_wait_cond) begin
                    freeze      = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    w_stall_inc = 1'b1;
                    w_wait_nxt  = TO_W'(1);
                    w_next      = MEM_WAIT;
                end else if (mem_branch_taken && (r_state != FLUSH)) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    w_flush_inc  = 1'b1;
                    w_next       = FLUSH;
                end else if (w_hazard && (r_state == RUN)) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    w_stall_inc  = 1'b1;
                    w_next       = LOAD_STALL;
                end
            end
        endcase

        if (reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_bubble  = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_flush  = 1'b0;
            freeze        = 1'b0;
            w_stall_inc   = 1'b0;
            w_flush_inc   = 1'b0;
            w_timeout_set = 1'b0;
            w_next        = RUN;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_stall_inc),
        .clr   (cnt_clear),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_flush_inc),
        .clr   (cnt_clear),
        .count (flush_count)
    );

    assign mem_timeout = r_mem_timeout;
    assign state       = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small counter width and timeout.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned MEM_TO = 4;
    localparam int unsigned TO_W = 3;

    // Enable vector: {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, freeze}
    localparam logic [6:0] EN_RST   = 7'b0000000;
    localparam logic [6:0] EN_IDLE  = 7'b1100000;
    localparam logic [6:0] EN_STALL = 7'b0010000;
    localparam logic [6:0] EN_FLUSH = 7'b1101110;
    localparam logic [6:0] EN_FRZ   = 7'b0000001;
    localparam logic [6:0] EN_TOUT  = 7'b1100010;

    logic             clock = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs2, ex_mem_read, mem_branch_taken;
    logic             mem_req, mem_ready, cnt_clear;
    logic             pc_write, if_id_write, id_ex_bubble;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, freeze, mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [1:0]       state;
    logic [6:0]       en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    assign en = {pc_write, if_id_write, id_ex_bubble, if_id_flush,
                 id_ex_flush, ex_mem_flush, freeze};

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO), .TO_W(TO_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs2      (id_uses_rs2),
        .ex_mem_read      (ex_mem_read),
        .ex_rd            (ex_rd),
        .mem_branch_taken (mem_branch_taken),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .cnt_clear        (cnt_clear),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .id_ex_bubble     (id_ex_bubble),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .freeze           (freeze),
        .mem_timeout      (mem_timeout),
        .stall_count      (stall_count),
        .flush_count      (flush_count),
        .state            (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; mem_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; cnt_clear = 1'b0;
    endtask

    task automatic set_hazard();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        check("rst_en", 32'(en), 32'(EN_RST));
        check("rst_state", 32'(state), 32'd0);
        check("rst_stall_cnt", 32'(stall_count), 32'd0);
        check("rst_flush_cnt", 32'(flush_count), 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        reset = 1'b0;
        #1;
        check("idle_en", 32'(en), 32'(EN_IDLE));

        // Load-use on rs1: one bubble, then back to RUN
        set_hazard();
        #1;
        check("lu_en", 32'(en), 32'(EN_STALL));
        tick();
        check("lu_state1", 32'(state), 32'd1);
        check("lu_stall_cnt", 32'(stall_count), 32'd1);
        check("lu_suppressed", 32'(en), 32'(EN_IDLE));
        tick();
        clear_inputs();
        #1;
        check("lu_state0", 32'(state), 32'd0);

        // x0 destination and unused rs2 never stall
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #1;
        check("x0_no_stall", 32'(en), 32'(EN_IDLE));
        ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3; id_uses_rs2 = 1'b0;
        #1;
        check("rs2_unused", 32'(en), 32'(EN_IDLE));
        id_uses_rs2 = 1'b1;
        #1;
        check("rs2_used", 32'(en), 32'(EN_STALL));
        tick();
        clear_inputs();
        check("rs2_stall_cnt", 32'(stall_count), 32'd2);
        tick();

        // Branch outranks a simultaneous load-use
        set_hazard();
        mem_branch_taken = 1'b1;
        #1;
        check("br_en", 32'(en), 32'(EN_FLUSH));
        tick();
        mem_branch_taken = 1'b0;
        #1;
        check("br_state", 32'(state), 32'd2);
        check("br_flush_cnt", 32'(flush_count), 32'd1);
        check("br_hazard_ignored", 32'(en), 32'(EN_IDLE));
        tick();
        clear_inputs();
        #1;
        check("br_back_run", 32'(state), 32'd0);

        // Three wait cycles then ready
        mem_req = 1'b1;
        #1;
        check("mw_en0", 32'(en), 32'(EN_FRZ));
        for (int i = 1; i < 3; i++) begin
            tick();
            check("mw_state", 32'(state), 32'd3);
            check("mw_en", 32'(en), 32'(EN_FRZ));
        end
        tick();
        mem_ready = 1'b1;
        #1;
        check("mw_ready_en", 32'(en), 32'(EN_IDLE));
        tick();
        clear_inputs();
        check("mw_state_run", 32'(state), 32'd0);
        check("mw_stall_cnt", 32'(stall_count), 32'd5);

        // Timeout after MEM_TO wait cycles
        mem_req = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("to_frz", 32'(en), 32'(EN_FRZ));
            tick();
        end
        check("to_en", 32'(en), 32'(EN_TOUT));
        check("to_not_yet", 32'(mem_timeout), 32'd0);
        tick();
        clear_inputs();
        check("to_flag", 32'(mem_timeout), 32'd1);
        check("to_state", 32'(state), 32'd0);
        check("to_stall_cnt", 32'(stall_count), 32'd9);
        tick();
        check("to_sticky", 32'(mem_timeout), 32'd1);

        // Stall counter saturation, then clear wins over a stall
        set_hazard();
        for (int i = 0; i < 28; i++) tick();
        check("sat_stall_cnt", 32'(stall_count), 32'd15);
        check("sat_state", 32'(state), 32'd0);
        cnt_clear = 1'b1;
        #1;
        check("clr_en", 32'(en), 32'(EN_STALL));
        tick();
        clear_inputs();
        check("clr_stall_cnt", 32'(stall_count), 32'd0);
        check("clr_flush_cnt", 32'(flush_count), 32'd0);
        tick();

        // Reset mid-wait: back to RUN, no timeout flag
        mem_req = 1'b1;
        tick();
        tick();
        check("rmw_state", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        check("rmw_rst_en", 32'(en), 32'(EN_RST));
        for (int i = 0; i < 5; i++) tick();
        check("rmw_state_run", 32'(state), 32'd0);
        check("rmw_no_timeout", 32'(mem_timeout), 32'd0);
        reset = 1'b0;
        clear_inputs();
        #1;
        check("rmw_idle", 32'(en), 32'(EN_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
